// File: rtl/pulse_sched_pkg.sv
// Shared types and helpers for the pulse_sched scheduler.
package pulse_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    // Requested spacing below pulse_gen's recovery time is raised to that minimum.
    function automatic logic [31:0] clamp_gap(input logic [31:0] gap, input logic [31:0] min_gap);
        return (gap < min_gap) ? min_gap : gap;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: picks the first request strictly after i_ptr, wrapping.
module rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    logic [IDX_W-1:0] w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_j     = '0;
        if (i_en) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                w_j = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
                if (!o_valid && i_req[w_j]) begin
                    o_valid      = 1'b1;
                    o_grant[w_j] = 1'b1;
                    o_idx        = w_j;
                end
            end
        end
    end

endmodule

// File: rtl/pulse_sched.sv
// Shares one pulse_gen among NUM_REQ burst requesters, spacing triggers by at least MIN_GAP.
// Optional build macro PULSE_SCHED_PRIO_EN: requester 0 takes strict priority over the rotation.
module pulse_sched #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8,
    parameter int GAP_W   = 16,
    parameter int MIN_GAP = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*CNT_W-1:0]     req_count,
    input  logic [NUM_REQ*GAP_W-1:0]     req_gap,
    output logic                         o_trig,
    output logic [$clog2(NUM_REQ)-1:0]   o_grant_id,
    output logic                         busy,
    output logic [NUM_REQ-1:0]           done
);
    import pulse_sched_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [GAP_W:0] HOLD_LOAD = (MIN_GAP > 2) ? (GAP_W+1)'(MIN_GAP - 3) : '0;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [IDX_W-1:0]   r_grant_id, w_grant_id_nxt;
    logic [CNT_W-1:0]   r_remaining, w_remaining_nxt;
    logic [GAP_W:0]     r_spacing, w_spacing_nxt;
    logic [GAP_W:0]     r_gap, w_gap_nxt;
    logic               r_zero, w_zero_nxt;
    logic               r_trig, w_trig_nxt;
    logic               r_busy;
    logic [NUM_REQ-1:0] r_ready, w_ready_nxt;
    logic [NUM_REQ-1:0] r_done, w_done_nxt;
    logic               w_term;

    logic [NUM_REQ-1:0] w_arb_req, w_arb_grant, w_sel_grant;
    logic [IDX_W-1:0]   w_arb_idx, w_sel_idx;
    logic               w_arb_valid, w_sel_valid, w_sel_moves_ptr;
    logic [CNT_W-1:0]   w_cnt_sel;
    logic [GAP_W-1:0]   w_gap_sel;
    logic [GAP_W:0]     w_spacing_sel;

    rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arb (
        .i_req   (w_arb_req),
        .i_ptr   (r_rr_ptr),
        .i_en    (r_state == IDLE),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

`ifdef PULSE_SCHED_PRIO_EN
    // Requester 0 bypasses the rotation and leaves the pointer untouched.
    assign w_arb_req       = {req_valid[NUM_REQ-1:1], 1'b0};
    assign w_sel_valid     = req_valid[0] | w_arb_valid;
    assign w_sel_grant     = req_valid[0] ? NUM_REQ'(1) : w_arb_grant;
    assign w_sel_idx       = req_valid[0] ? '0 : w_arb_idx;
    assign w_sel_moves_ptr = ~req_valid[0];
`else
    assign w_arb_req       = req_valid;
    assign w_sel_valid     = w_arb_valid;
    assign w_sel_grant     = w_arb_grant;
    assign w_sel_idx       = w_arb_idx;
    assign w_sel_moves_ptr = 1'b1;
`endif

    assign w_cnt_sel     = req_count[int'(w_sel_idx)*CNT_W +: CNT_W];
    assign w_gap_sel     = req_gap[int'(w_sel_idx)*GAP_W +: GAP_W];
    assign w_spacing_sel = (GAP_W+1)'(clamp_gap(32'(w_gap_sel), 32'(MIN_GAP)));

    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_grant_id_nxt  = r_grant_id;
        w_remaining_nxt = r_remaining;
        w_spacing_nxt   = r_spacing;
        w_gap_nxt       = r_gap;
        w_zero_nxt      = r_zero;
        w_trig_nxt      = 1'b0;
        w_ready_nxt     = '0;
        w_done_nxt      = '0;
        w_term          = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_sel_valid) begin
                    w_grant_id_nxt  = w_sel_idx;
                    w_ready_nxt     = w_sel_grant;
                    w_remaining_nxt = w_cnt_sel;
                    w_spacing_nxt   = w_spacing_sel;
                    if (w_sel_moves_ptr) w_rr_ptr_nxt = w_sel_idx;
                    if (w_cnt_sel != '0) begin
                        w_state_nxt = FIRE;
                        w_trig_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = HOLD;
                        w_zero_nxt  = 1'b1;
                    end
                end
            end
            FIRE: begin
                w_remaining_nxt = r_remaining - 1'b1;
                // WAIT lasts S-1 cycles, so it is loaded with S-2 and exits on zero.
                if (r_remaining > CNT_W'(1)) begin
                    w_state_nxt = WAIT;
                    w_gap_nxt   = r_spacing - (GAP_W+1)'(2);
                end else begin
                    w_term = 1'b1;
                end
            end
            WAIT: begin
                if (r_gap == '0) begin
                    w_state_nxt = FIRE;
                    w_trig_nxt  = 1'b1;
                end else begin
                    w_gap_nxt = r_gap - 1'b1;
                end
            end
            HOLD: begin
                // A zero-count burst spends its acceptance cycle here in place of a FIRE.
                if (r_zero) begin
                    w_zero_nxt = 1'b0;
                    w_term     = 1'b1;
                end else if (r_gap == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_gap_nxt = r_gap - 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_term) begin
            w_done_nxt = NUM_REQ'(1) << r_grant_id;
            if (MIN_GAP == 2) begin
                w_state_nxt = IDLE;
            end else begin
                w_state_nxt = HOLD;
                w_gap_nxt   = HOLD_LOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= IDX_W'(NUM_REQ - 1);
            r_grant_id  <= '0;
            r_remaining <= '0;
            r_spacing   <= '0;
            r_gap       <= '0;
            r_zero      <= 1'b0;
            r_trig      <= 1'b0;
            r_busy      <= 1'b0;
            r_ready     <= '0;
            r_done      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_grant_id  <= w_grant_id_nxt;
            r_remaining <= w_remaining_nxt;
            r_spacing   <= w_spacing_nxt;
            r_gap       <= w_gap_nxt;
            r_zero      <= w_zero_nxt;
            r_trig      <= w_trig_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_ready     <= w_ready_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign req_ready  = r_ready;
    assign o_trig     = r_trig;
    assign o_grant_id = r_grant_id;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
